hyperspace_caravel: RTL and testbench

HYPERSPACE_CARAVEL -- requirements
Module: hyperspace_caravel

---
 rtl/hyperspace_caravel.sv | 111 +++++++++++
 tb/tb_hyperspace_caravel.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hyperspace_caravel.sv
// hyperspace_caravel: packs up to four 8-bit samples into a group and
// streams three 16-bit statistics words (sum, max/min, b0*b3) per group.
module hyperspace_caravel #(
  parameter int IN_W  = 8,
  parameter int OUT_W = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_last
);

  localparam logic [0:0] COLLECT = 1'b0;
  localparam logic [0:0] EMIT    = 1'b1;

  localparam int PAD = OUT_W - IN_W;

  logic [0:0]      state;
  logic [1:0]      cnt;
  logic [1:0]      widx;
  logic            grp_last;
  logic [IN_W-1:0] b [4];

  logic            in_acc;
  logic            out_acc;
  logic [OUT_W-1:0] sum;
  logic [OUT_W-1:0] prod;
  logic [IN_W-1:0] mx01;
  logic [IN_W-1:0] mx23;
  logic [IN_W-1:0] mn01;
  logic [IN_W-1:0] mn23;
  logic [IN_W-1:0] mx;
  logic [IN_W-1:0] mn;

  // Handshake outputs are forced low while reset is held.
  assign in_ready  = ~reset & (state == COLLECT);
  assign out_valid = ~reset & (state == EMIT);
  assign in_acc    = in_valid & in_ready;
  assign out_acc   = out_valid & out_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= COLLECT;
      cnt      <= 2'd0;
      widx     <= 2'd0;
      grp_last <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        b[i] <= '0;
      end
    end else if (state == COLLECT) begin
      if (in_acc) begin
        b[cnt] <= in_data;
        cnt    <= cnt + 2'd1;
        if (cnt == 2'd3 || in_last) begin
          state    <= EMIT;
          widx     <= 2'd0;
          grp_last <= in_last;
        end
      end
    end else begin
      if (out_acc) begin
        if (widx == 2'd2) begin
          state    <= COLLECT;
          cnt      <= 2'd0;
          widx     <= 2'd0;
          grp_last <= 1'b0;
          for (int i = 0; i < 4; i++) begin
            b[i] <= '0;
          end
        end else begin
          widx <= widx + 2'd1;
        end
      end
    end
  end

  // Slots are frozen during EMIT, so the words stay stable under stall.
  assign sum = {{PAD{1'b0}}, b[0]} + {{PAD{1'b0}}, b[1]}
             + {{PAD{1'b0}}, b[2]} + {{PAD{1'b0}}, b[3]};

  assign prod = {{PAD{1'b0}}, b[0]} * {{PAD{1'b0}}, b[3]};

  assign mx01 = (b[0] > b[1]) ? b[0] : b[1];
  assign mx23 = (b[2] > b[3]) ? b[2] : b[3];
  assign mn01 = (b[0] < b[1]) ? b[0] : b[1];
  assign mn23 = (b[2] < b[3]) ? b[2] : b[3];
  assign mx   = (mx01 > mx23) ? mx01 : mx23;
  assign mn   = (mn01 < mn23) ? mn01 : mn23;

  always_comb begin
    out_data = '0;
    out_last = 1'b0;
    if (out_valid) begin
      unique case (1'b1)
        (widx == 2'd0): out_data = sum;
        (widx == 2'd1): out_data = {mx, mn};
        default: begin
          out_data = prod;
          out_last = grp_last;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_hyperspace_caravel.sv
// tb_hyperspace_caravel: table vectors, corner-case sequences and a
// randomized stream checked against a queue-based reference model.
module tb_hyperspace_caravel;

  logic        clock;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic        in_last;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out_data;
  logic        out_last;

  hyperspace_caravel #(.IN_W(8), .OUT_W(16)) dut (
    .clock    (clock),
    .reset    (reset),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .in_last  (in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct packed {
    logic [3:0][7:0]  s;
    logic [2:0]       n;
    logic             lst;
    logic [2:0][15:0] w;
    logic             ol;
  } vec_t;

  int n_checks = 0;
  int n_errs   = 0;

  logic        o_ir;
  logic        o_ov;
  logic [15:0] o_od;
  logic        o_ol;

  vec_t tbl [8];

  logic [7:0]  grp [$];
  logic [15:0] exp_d [$];
  logic        exp_l [$];

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s got=%h expected=%h", name, got, exp);
    end
  endtask

  // Drive at the falling edge, then sample outputs before the next rise.
  task automatic step(input logic rst, input logic v, input logic [7:0] d,
                      input logic l, input logic r);
    @(negedge clock);
    reset     = rst;
    in_valid  = v;
    in_data   = d;
    in_last   = l;
    out_ready = r;
    #1;
    o_ir = in_ready;
    o_ov = out_valid;
    o_od = out_data;
    o_ol = out_last;
  endtask

  task automatic run_vec(input int k);
    vec_t t;
    t = tbl[k];
    for (int i = 0; i < int'(t.n); i++) begin
      step(1'b0, 1'b1, t.s[i], t.lst && (i == int'(t.n) - 1), 1'b1);
      chk($sformatf("v%0d_in_ready%0d", k, i), {31'b0, o_ir}, 32'd1);
    end
    for (int j = 0; j < 3; j++) begin
      step(1'b0, 1'b1, 8'h5A, 1'b0, 1'b1);
      chk($sformatf("v%0d_ov%0d", k, j), {31'b0, o_ov}, 32'd1);
      chk($sformatf("v%0d_ir%0d", k, j), {31'b0, o_ir}, 32'd0);
      chk($sformatf("v%0d_w%0d", k, j), {16'b0, o_od}, {16'b0, t.w[j]});
      chk($sformatf("v%0d_last%0d", k, j), {31'b0, o_ol},
          {31'b0, (j == 2) ? t.ol : 1'b0});
    end
  endtask

  task automatic idle_check(input string name);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk({name, "_ir"}, {31'b0, o_ir}, 32'd1);
    chk({name, "_ov"}, {31'b0, o_ov}, 32'd0);
  endtask

  task automatic model_close(input logic l);
    int unsigned sm;
    int unsigned mx;
    int unsigned mn;
    int unsigned v [4];
    for (int i = 0; i < 4; i++) v[i] = (i < grp.size()) ? grp[i] : 0;
    sm = 0; mx = 0; mn = 255;
    for (int i = 0; i < 4; i++) begin
      sm += v[i];
      if (v[i] > mx) mx = v[i];
      if (v[i] < mn) mn = v[i];
    end
    exp_d.push_back(16'(sm));
    exp_l.push_back(1'b0);
    exp_d.push_back(16'(mx * 256 + mn));
    exp_l.push_back(1'b0);
    exp_d.push_back(16'(v[0] * v[3]));
    exp_l.push_back(l);
    grp.delete();
  endtask

  initial begin
    int acc;
    int words;
    int cyc;
    logic v;
    logic l;
    logic r;
    logic [7:0] d;

    tbl[0] = '{s: {8'h04, 8'h03, 8'h02, 8'h01}, n: 3'd4, lst: 1'b0,
               w: {16'h0004, 16'h0401, 16'h000A}, ol: 1'b0};
    tbl[1] = '{s: {8'hFF, 8'hFF, 8'hFF, 8'hFF}, n: 3'd4, lst: 1'b1,
               w: {16'hFE01, 16'hFFFF, 16'h03FC}, ol: 1'b1};
    tbl[2] = '{s: {8'h00, 8'h00, 8'h20, 8'h10}, n: 3'd2, lst: 1'b1,
               w: {16'h0000, 16'h2000, 16'h0030}, ol: 1'b1};
    tbl[3] = '{s: {8'h08, 8'h07, 8'h06, 8'h05}, n: 3'd4, lst: 1'b0,
               w: {16'h0028, 16'h0805, 16'h001A}, ol: 1'b0};
    tbl[4] = '{s: {8'h00, 8'h00, 8'h00, 8'h07}, n: 3'd1, lst: 1'b1,
               w: {16'h0000, 16'h0700, 16'h0007}, ol: 1'b1};
    tbl[5] = '{s: {8'hC8, 8'h01, 8'h80, 8'h00}, n: 3'd4, lst: 1'b0,
               w: {16'h0000, 16'hC800, 16'h0149}, ol: 1'b0};
    tbl[6] = '{s: {8'h00, 8'h20, 8'h10, 8'h03}, n: 3'd3, lst: 1'b1,
               w: {16'h0000, 16'h2000, 16'h0033}, ol: 1'b1};
    tbl[7] = '{s: {8'h0D, 8'h02, 8'h01, 8'h0C}, n: 3'd4, lst: 1'b0,
               w: {16'h009C, 16'h0D01, 16'h001C}, ol: 1'b0};

    reset = 1'b1; in_valid = 1'b0; in_data = 8'h00;
    in_last = 1'b0; out_ready = 1'b0;

    step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
    step(1'b1, 1'b1, 8'hAA, 1'b1, 1'b1);
    chk("rst_ir", {31'b0, o_ir}, 32'd0);
    chk("rst_ov", {31'b0, o_ov}, 32'd0);
    chk("rst_ol", {31'b0, o_ol}, 32'd0);
    chk("rst_od", {16'b0, o_od}, 32'd0);
    idle_check("post_rst");

    for (int k = 0; k < 8; k++) begin
      run_vec(k);
    end
    idle_check("after_tbl");

    // Backpressure during w1.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'(i + 1), 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
    chk("bp_w0", {16'b0, o_od}, 32'h000A);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 8'h77, 1'b1, 1'b0);
      chk("bp_hold_w1", {16'b0, o_od}, 32'h0401);
      chk("bp_hold_ov", {31'b0, o_ov}, 32'd1);
      chk("bp_hold_ir", {31'b0, o_ir}, 32'd0);
      chk("bp_hold_ol", {31'b0, o_ol}, 32'd0);
    end
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b1);
    chk("bp_w1_take", {16'b0, o_od}, 32'h0401);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("bp_w2", {16'b0, o_od}, 32'h0004);
    chk("bp_w2_ov", {31'b0, o_ov}, 32'd1);
    idle_check("bp_done");

    // Reset after two samples discards the partial group.
    step(1'b0, 1'b1, 8'hAA, 1'b0, 1'b1);
    step(1'b0, 1'b1, 8'hBB, 1'b0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("rmid_ov", {31'b0, o_ov}, 32'd0);
    chk("rmid_ir", {31'b0, o_ir}, 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("rmid_ir_rise", {31'b0, o_ir}, 32'd1);
    idle_check("rmid_idle");
    run_vec(3);

    // Reset in the middle of EMIT.
    for (int i = 0; i < 4; i++) step(1'b0, 1'b1, 8'hE0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("remit_w0", {16'b0, o_od}, 32'h0380);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
    chk("remit_ov", {31'b0, o_ov}, 32'd0);
    chk("remit_od", {16'b0, o_od}, 32'd0);
    idle_check("remit_idle");
    idle_check("remit_idle2");
    run_vec(0);

    // Random stream of 2048 samples versus the reference model.
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    acc = 0; words = 0; cyc = 0;
    grp.delete(); exp_d.delete(); exp_l.delete();
    while (cyc < 40000 && (acc < 2048 || exp_d.size() > 0)) begin
      cyc++;
      v = (acc < 2048) && ($urandom_range(0, 3) != 0);
      d = 8'($urandom);
      l = (acc == 2047);
      r = ($urandom_range(0, 3) != 0);
      step(1'b0, v, d, l, r);
      if (v && o_ir) begin
        grp.push_back(d);
        acc++;
        if (grp.size() == 4 || l) model_close(l);
      end
      if (o_ov && r) begin
        words++;
        if (exp_d.size() == 0) begin
          chk("rand_extra_word", {16'b0, o_od}, 32'hFFFF_FFFF);
        end else begin
          chk($sformatf("rand_w%0d_data", words), {16'b0, o_od},
              {16'b0, exp_d.pop_front()});
          chk($sformatf("rand_w%0d_last", words), {31'b0, o_ol},
              {31'b0, exp_l.pop_front()});
        end
      end
    end
    chk("rand_accepted", acc, 2048);
    chk("rand_words", words, 1536);
    chk("rand_drained", exp_d.size(), 0);
    idle_check("rand_end");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
